// File: rtl/hazard_forward_unit_pkg.sv
// Shared pipeline definitions: widths, forward-select codes, stage register layouts.
// Latency: none (types and constants only).
// Backpressure: none; consumers stall through the hazard unit's stall output.
package hazard_forward_unit_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;

  // Operand source selects driven toward the EX-stage operand muxes
  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_WB    = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

  typedef logic [REG_W-1:0]  reg_num_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef struct packed {
    data_t    alu_result;
    reg_num_t dest;
    logic     reg_write;
    logic     mem_read;
    logic     mem_to_reg;
  } ex_mem_t;

  typedef struct packed {
    data_t    alu_result;
    data_t    read_data;
    reg_num_t dest;
    logic     reg_write;
    logic     mem_to_reg;
  } mem_wb_t;

  // A producer is only relevant if it writes a real register (never $0)
  function automatic logic reg_hit(input reg_num_t src, input reg_num_t dest, input logic wr);
    return wr && (dest != '0) && (dest == src);
  endfunction

endpackage

// File: rtl/hazard_forward_unit_forward_compare.sv
// Two-level producer match for one source register: near producer wins over far.
// Latency: combinational.
// Backpressure: none.
module forward_compare
  import hazard_forward_unit_pkg::*;
(
  input  logic [REG_W-1:0] src,
  input  logic [REG_W-1:0] near_dest,
  input  logic             near_write,
  input  logic [REG_W-1:0] far_dest,
  input  logic             far_write,
  output logic [1:0]       sel
);

  // Nearest (youngest) producer has priority so the newest value is used
  always_comb begin
    sel = FWD_REG;
    if (reg_hit(src, near_dest, near_write)) begin
      sel = FWD_EXMEM;
    end else if (reg_hit(src, far_dest, far_write)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// EX/MEM and MEM/WB pipeline registers with operand forwarding and load-use stall detection.
// Latency: EX inputs reach write-back outputs after 2 clk edges; selects and stall are combinational.
// Backpressure: stall holds PC/IF-ID and requests an ID/EX bubble. Macro FORWARDING_EN enables forwarding;
// without it selects are tied to register file and stall covers every in-flight RAW dependence.
module hazard_forward_unit
  import hazard_forward_unit_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_W-1:0]  id_ex_rs,
  input  logic [REG_W-1:0]  id_ex_rt,
  input  logic [REG_W-1:0]  id_ex_dest,
  input  logic              id_ex_reg_write,
  input  logic              id_ex_mem_read,
  input  logic              id_ex_mem_to_reg,
  input  logic [REG_W-1:0]  if_id_rs,
  input  logic [REG_W-1:0]  if_id_rt,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic [DATA_W-1:0] ex_mem_alu_result,
  output logic [DATA_W-1:0] mem_wb_write_back_result,
  output logic [REG_W-1:0]  mem_wb_dest,
  output logic              mem_wb_reg_write,
  output logic [1:0]        Forward_A,
  output logic [1:0]        Forward_B,
  output logic              stall,
  output logic [15:0]       stall_count
);

  ex_mem_t    ex_mem;
  mem_wb_t    mem_wb;
  logic [1:0] sel_a;
  logic [1:0] sel_b;

  // Advance EX -> EX/MEM -> MEM/WB every cycle; reset drops everything in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_mem <= '0;
      mem_wb <= '0;
    end else begin
      ex_mem.alu_result <= alu_result;
      ex_mem.dest       <= id_ex_dest;
      ex_mem.reg_write  <= id_ex_reg_write;
      ex_mem.mem_read   <= id_ex_mem_read;
      ex_mem.mem_to_reg <= id_ex_mem_to_reg;
      mem_wb.alu_result <= ex_mem.alu_result;
      mem_wb.read_data  <= mem_read_data;
      mem_wb.dest       <= ex_mem.dest;
      mem_wb.reg_write  <= ex_mem.reg_write;
      mem_wb.mem_to_reg <= ex_mem.mem_to_reg;
    end
  end

  assign ex_mem_alu_result = ex_mem.alu_result;
  assign mem_wb_dest       = mem_wb.dest;
  assign mem_wb_reg_write  = mem_wb.reg_write;

  // Write-back value: load data for loads, ALU result otherwise
  always_comb begin
    mem_wb_write_back_result = mem_wb.alu_result;
    if (mem_wb.mem_to_reg) begin
      mem_wb_write_back_result = mem_wb.read_data;
    end
  end

`ifdef FORWARDING_EN

  // Operand A: EX/MEM (never a load, its data is not ready yet) beats MEM/WB
  forward_compare u_cmp_a (
    .src        (id_ex_rs),
    .near_dest  (ex_mem.dest),
    .near_write (ex_mem.reg_write & ~ex_mem.mem_read),
    .far_dest   (mem_wb.dest),
    .far_write  (mem_wb.reg_write),
    .sel        (sel_a)
  );

  // Operand B: same priority rule on rt
  forward_compare u_cmp_b (
    .src        (id_ex_rt),
    .near_dest  (ex_mem.dest),
    .near_write (ex_mem.reg_write & ~ex_mem.mem_read),
    .far_dest   (mem_wb.dest),
    .far_write  (mem_wb.reg_write),
    .sel        (sel_b)
  );

  assign Forward_A = sel_a;
  assign Forward_B = sel_b;

  // Only a load in EX feeding the instruction in ID cannot be forwarded in time
  always_comb begin
    stall = 1'b0;
    if (id_ex_mem_read &&
        (reg_hit(if_id_rs, id_ex_dest, 1'b1) || reg_hit(if_id_rt, id_ex_dest, 1'b1))) begin
      stall = 1'b1;
    end
  end

`else

  // Without forwarding the comparators look one stage earlier: ID sources
  // against EX and EX/MEM producers. MEM/WB needs no check because the
  // register file writes before it is read.
  forward_compare u_cmp_a (
    .src        (if_id_rs),
    .near_dest  (id_ex_dest),
    .near_write (id_ex_reg_write),
    .far_dest   (ex_mem.dest),
    .far_write  (ex_mem.reg_write),
    .sel        (sel_a)
  );

  forward_compare u_cmp_b (
    .src        (if_id_rt),
    .near_dest  (id_ex_dest),
    .near_write (id_ex_reg_write),
    .far_dest   (ex_mem.dest),
    .far_write  (ex_mem.reg_write),
    .sel        (sel_b)
  );

  assign Forward_A = FWD_REG;
  assign Forward_B = FWD_REG;

  // Any in-flight producer of an ID source holds the pipe until it reaches write-back
  always_comb begin
    stall = (sel_a != FWD_REG) || (sel_b != FWD_REG);
  end

  // EX source numbers and the load flag only steer forwarding, which is absent here
  logic unused_nofwd;
  assign unused_nofwd = ^{id_ex_rs, id_ex_rt, ex_mem.mem_read};

`endif

  // Saturating count of stalled cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count <= 16'd0;
    end else if (stall && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed pipeline scenarios for hazard_forward_unit; the bench plays the ID/EX stage.
// Expected values are hand-computed; both builds of FORWARDING_EN are covered by ifdef.
`timescale 1ns/1ps
module tb_hazard_forward_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_ex_rs, id_ex_rt, id_ex_dest, if_id_rs, if_id_rt;
  logic        id_ex_reg_write, id_ex_mem_read, id_ex_mem_to_reg;
  logic [31:0] alu_result, mem_read_data;
  logic [31:0] ex_mem_alu_result, mem_wb_write_back_result;
  logic [4:0]  mem_wb_dest;
  logic        mem_wb_reg_write;
  logic [1:0]  Forward_A, Forward_B;
  logic        stall;
  logic [15:0] stall_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hazard_forward_unit dut (
    .clk                      (clk),
    .reset                    (reset),
    .id_ex_rs                 (id_ex_rs),
    .id_ex_rt                 (id_ex_rt),
    .id_ex_dest               (id_ex_dest),
    .id_ex_reg_write          (id_ex_reg_write),
    .id_ex_mem_read           (id_ex_mem_read),
    .id_ex_mem_to_reg         (id_ex_mem_to_reg),
    .if_id_rs                 (if_id_rs),
    .if_id_rt                 (if_id_rt),
    .alu_result               (alu_result),
    .mem_read_data            (mem_read_data),
    .ex_mem_alu_result        (ex_mem_alu_result),
    .mem_wb_write_back_result (mem_wb_write_back_result),
    .mem_wb_dest              (mem_wb_dest),
    .mem_wb_reg_write         (mem_wb_reg_write),
    .Forward_A                (Forward_A),
    .Forward_B                (Forward_B),
    .stall                    (stall),
    .stall_count              (stall_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_ex_mem_alu"}, ex_mem_alu_result, 32'd0);
    chk({pfx, "_wb_result"},  mem_wb_write_back_result, 32'd0);
    chk({pfx, "_wb_dest"},    {27'd0, mem_wb_dest}, 32'd0);
    chk({pfx, "_wb_we"},      {31'd0, mem_wb_reg_write}, 32'd0);
    chk({pfx, "_fwd_a"},      {30'd0, Forward_A}, 32'd0);
    chk({pfx, "_fwd_b"},      {30'd0, Forward_B}, 32'd0);
    chk({pfx, "_stall"},      {31'd0, stall}, 32'd0);
    chk({pfx, "_stall_cnt"},  {16'd0, stall_count}, 32'd0);
  endtask

  task automatic set_ex(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dest,
                        input logic rw, input logic mr, input logic m2r, input logic [31:0] alu);
    id_ex_rs = rs; id_ex_rt = rt; id_ex_dest = dest;
    id_ex_reg_write = rw; id_ex_mem_read = mr; id_ex_mem_to_reg = m2r;
    alu_result = alu;
  endtask

  task automatic set_id(input logic [4:0] rs, input logic [4:0] rt);
    if_id_rs = rs; if_id_rt = rt;
  endtask

  task automatic bubble();
    set_ex(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  // Advance one clock; inputs change 1ns after the edge, checks follow 1ns later
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  int exp_cnt;

  initial begin
    // Reset with busy-looking inputs: registers must stay cleared
    reset = 1'b1;
    set_ex(5'd1, 5'd2, 5'd7, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF);
    set_id(5'd0, 5'd0);
    mem_read_data = 32'h12345678;
    next();
    next();
    chk_all_zero("rst");
    reset = 1'b0;

`ifdef FORWARDING_EN
    // add $3,$1,$2 (5+7=0xC) then sub $4,$3,$5 back-to-back
    set_ex(5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 32'h0000000C);
    set_id(5'd3, 5'd5);
    #1 chk("addsub_no_stall", {31'd0, stall}, 32'd0);
    next();
    set_ex(5'd3, 5'd5, 5'd4, 1'b1, 1'b0, 1'b0, 32'h00000009);
    set_id(5'd0, 5'd0);
    #1;
    chk("addsub_fwd_a", {30'd0, Forward_A}, 32'd2);
    chk("addsub_fwd_b", {30'd0, Forward_B}, 32'd0);
    chk("addsub_exmem", ex_mem_alu_result, 32'h0000000C);

    // add $3 (0x20), nop, or $6,$7,$3
    next();
    set_ex(5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 32'h00000020);
    next();
    bubble();
    next();
    set_ex(5'd7, 5'd3, 5'd6, 1'b1, 1'b0, 1'b0, 32'd0);
    #1;
    chk("or_fwd_b", {30'd0, Forward_B}, 32'd1);
    chk("or_fwd_a", {30'd0, Forward_A}, 32'd0);
    chk("or_wb_val", mem_wb_write_back_result, 32'h00000020);

    // lw $2,0($1) then add $4,$2,$2
    next();
    set_ex(5'd1, 5'd0, 5'd2, 1'b1, 1'b1, 1'b1, 32'h00000100);
    set_id(5'd2, 5'd2);
    #1;
    chk("lw_stall", {31'd0, stall}, 32'd1);
    chk("lw_cnt0", {16'd0, stall_count}, 32'd0);
    next();
    set_ex(5'd2, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0); // bubble; rs=2 must not see the load in EX/MEM
    mem_read_data = 32'hCAFE0001;
    #1;
    chk("lw_stall_once", {31'd0, stall}, 32'd0);
    chk("lw_cnt1", {16'd0, stall_count}, 32'd1);
    chk("lw_no_exmem_fwd", {30'd0, Forward_A}, 32'd0);
    next();
    mem_read_data = 32'd0;
    set_ex(5'd2, 5'd2, 5'd4, 1'b1, 1'b0, 1'b0, 32'd0);
    set_id(5'd0, 5'd0);
    #1;
    chk("lw_fwd_a", {30'd0, Forward_A}, 32'd1);
    chk("lw_fwd_b", {30'd0, Forward_B}, 32'd1);
    chk("lw_wb_data", mem_wb_write_back_result, 32'hCAFE0001);

    // $8 written twice: EX/MEM (0x11) must beat MEM/WB (0x22)
    next();
    set_ex(5'd0, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0, 32'h00000022);
    next();
    set_ex(5'd0, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0, 32'h00000011);
    next();
    set_ex(5'd8, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 32'd0);
    #1;
    chk("dbl_fwd_a", {30'd0, Forward_A}, 32'd2);
    chk("dbl_exmem", ex_mem_alu_result, 32'h00000011);
    chk("dbl_wb", mem_wb_write_back_result, 32'h00000022);

    // $0 producers never forward or stall
    next();
    set_ex(5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 32'd0);
    set_id(5'd0, 5'd0);
    #1 chk("r0_no_stall", {31'd0, stall}, 32'd0);
    next();
    set_ex(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 32'h00000044);
    next();
    set_ex(5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0, 32'd0);
    #1;
    chk("r0_fwd_a", {30'd0, Forward_A}, 32'd0);
    chk("r0_fwd_b", {30'd0, Forward_B}, 32'd0);
    exp_cnt = 1;
`else
    // add $3,$1,$2 (0xC) then sub $4,$3,$5: two stall cycles, no forwarding
    set_ex(5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 32'h0000000C);
    set_id(5'd3, 5'd5);
    #1;
    chk("nf_stall_c0", {31'd0, stall}, 32'd1);
    chk("nf_fwd_a", {30'd0, Forward_A}, 32'd0);
    next();
    bubble();
    #1;
    chk("nf_stall_c1", {31'd0, stall}, 32'd1);
    chk("nf_exmem_add", ex_mem_alu_result, 32'h0000000C);
    chk("nf_cnt1", {16'd0, stall_count}, 32'd1);
    next();
    #1;
    chk("nf_stall_c2", {31'd0, stall}, 32'd0);
    chk("nf_cnt2", {16'd0, stall_count}, 32'd2);
    chk("nf_wb_add", mem_wb_write_back_result, 32'h0000000C);
    chk("nf_wb_dest", {27'd0, mem_wb_dest}, 32'd3);
    chk("nf_wb_we", {31'd0, mem_wb_reg_write}, 32'd1);
    next();
    set_ex(5'd3, 5'd5, 5'd4, 1'b1, 1'b0, 1'b0, 32'h00000009);
    set_id(5'd0, 5'd0);
    #1;
    chk("nf_sub_fwd_a", {30'd0, Forward_A}, 32'd0);
    chk("nf_sub_fwd_b", {30'd0, Forward_B}, 32'd0);
    next();
    bubble();
    #1 chk("nf_exmem_sub", ex_mem_alu_result, 32'h00000009);
    next();
    chk("nf_wb_sub", mem_wb_write_back_result, 32'h00000009);
    chk("nf_wb_dest_sub", {27'd0, mem_wb_dest}, 32'd4);

    // lw $2,0($1) then add $4,$2,$2: load data chosen over ALU address
    set_ex(5'd1, 5'd0, 5'd2, 1'b1, 1'b1, 1'b1, 32'h00000100);
    set_id(5'd2, 5'd2);
    #1 chk("nf_lw_stall0", {31'd0, stall}, 32'd1);
    next();
    bubble();
    mem_read_data = 32'hCAFE0001;
    #1;
    chk("nf_lw_stall1", {31'd0, stall}, 32'd1);
    chk("nf_lw_cnt", {16'd0, stall_count}, 32'd3);
    next();
    mem_read_data = 32'd0;
    #1;
    chk("nf_lw_stall2", {31'd0, stall}, 32'd0);
    chk("nf_lw_wb", mem_wb_write_back_result, 32'hCAFE0001);
    chk("nf_lw_cnt2", {16'd0, stall_count}, 32'd4);

    // Matching dest without reg_write is harmless; rt-only match stalls
    next();
    set_ex(5'd0, 5'd0, 5'd6, 1'b0, 1'b0, 1'b0, 32'd0);
    set_id(5'd6, 5'd6);
    #1 chk("nf_nowrite", {31'd0, stall}, 32'd0);
    set_ex(5'd0, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0, 32'd0);
    set_id(5'd9, 5'd6);
    #1 chk("nf_rt_match", {31'd0, stall}, 32'd1);
    next();
    bubble();
    set_id(5'd0, 5'd0);
    #1 chk("nf_cnt5", {16'd0, stall_count}, 32'd5);

    // $0 producers never stall, in EX or EX/MEM
    set_ex(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 32'h00000033);
    #1 chk("nf_r0_ex", {31'd0, stall}, 32'd0);
    next();
    bubble();
    #1;
    chk("nf_r0_exmem", {31'd0, stall}, 32'd0);
    chk("nf_r0_cnt", {16'd0, stall_count}, 32'd5);
    exp_cnt = 5;
`endif

    // Mid-stream reset discards in-flight results and the stall count
    chk("pre_rst_cnt", {16'd0, stall_count}, exp_cnt[31:0]);
    set_id(5'd0, 5'd0);
    set_ex(5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 32'h00000055);
    next();
    bubble();
    #1;
    chk("pre_rst_exmem", ex_mem_alu_result, 32'h00000055);
    reset = 1'b1;
    #1 chk_all_zero("midrst");
    next();
    reset = 1'b0;
    set_ex(5'd0, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0, 32'h00000077);
    next();
    bubble();
    #1 chk("post_rst_exmem", ex_mem_alu_result, 32'h00000077);
    next();
    chk("post_rst_wb", mem_wb_write_back_result, 32'h00000077);
    chk("post_rst_dest", {27'd0, mem_wb_dest}, 32'd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard bound so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout observed=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
